// File: rtl/rhs_cmd_sequencer_if.sv
// rhs_cmd_sequencer_if
// Purpose: the link between the command sequencer and an SPI master.
//   Handshake: the sequencer pulses spi_start for one cycle with spi_cmd
//   valid. It only does this while spi_done is low. The SPI master answers
//   by raising spi_done, with spi_rdata valid, and holds it high for one or
//   more cycles. The next spi_start waits until spi_done has fallen again.
// Signals:
//   spi_start  - one-cycle start pulse (sequencer -> SPI master)
//   spi_cmd    - 32-bit command word, held for the whole transfer
//   spi_done   - done level (SPI master -> sequencer)
//   spi_rdata  - 32-bit read data, valid while spi_done is high
interface rhs_cmd_sequencer_if;
  logic        spi_start;
  logic [31:0] spi_cmd;
  logic        spi_done;
  logic [31:0] spi_rdata;

  modport master (output spi_start, output spi_cmd, input spi_done, input spi_rdata);
  modport slave  (input spi_start, input spi_cmd, output spi_done, output spi_rdata);
endinterface

// File: rtl/rhs_cmd_sequencer.sv
// rhs_cmd_sequencer
// Purpose: replays a programmable table of 32-bit SPI commands, once per
//   trigger. For each command it captures the SPI read data into a result
//   strobe. It also watches for a hung SPI master and for misuse while busy.
// Ports:
//   clk, rst              - clock; synchronous active-high reset
//   enable, trigger       - a trigger is accepted only in IDLE with enable high
//   seq_len               - commands per sequence (0..DEPTH, larger is clamped)
//   cfg_we/addr/wdata     - command table write port (idle only)
//   spi                   - SPI master link (master modport)
//   res_valid/index/data  - per-command result strobe
//   seq_busy, seq_done    - sequence active; one-cycle end-of-sequence pulse
//   overrun, timeout, cfg_err - sticky error flags, cleared only by rst
//   dbg_state_o           - current FSM state, for observation
module rhs_cmd_sequencer #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          trigger,
  input  logic [LW-1:0] seq_len,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_wdata,
  rhs_cmd_sequencer_if.master spi,
  output logic          res_valid,
  output logic [AW-1:0] res_index,
  output logic [31:0]   res_data,
  output logic          seq_busy,
  output logic          seq_done,
  output logic          overrun,
  output logic          timeout,
  output logic          cfg_err,
  output logic [2:0]    dbg_state_o
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_FETCH        = 3'd1,
    S_ISSUE        = 3'd2,
    S_WAIT_DONE    = 3'd3,
    S_WAIT_RELEASE = 3'd4,
    S_NEXT         = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] index_q;
  logic [LW-1:0] len_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [31:0]   spi_cmd_q;
  logic          res_valid_q, seq_done_q;
  logic [AW-1:0] res_index_q;
  logic [31:0]   res_data_q;
  logic          overrun_q, timeout_q, cfg_err_q;

  logic          accept;
  logic [LW-1:0] len_clamp;
  logic          last;
  logic          tmo_hit;

  // A trigger in the same cycle as the seq_done pulse counts as an overrun
  // and is not accepted.
  assign accept    = (state_q == S_IDLE) && trigger && enable && !seq_done_q;
  assign len_clamp = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
  assign last      = (LW'(index_q) + LW'(1)) == len_q;
  assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (accept && (len_clamp != '0)) state_d = S_FETCH;
      S_FETCH:        state_d = S_ISSUE;
      // Stay in ISSUE while a stale done is still high, so start never overlaps it.
      S_ISSUE:        if (!spi.spi_done) state_d = S_WAIT_DONE;
      S_WAIT_DONE:    if (spi.spi_done) state_d = S_WAIT_RELEASE;
                      else if (tmo_hit) state_d = S_IDLE;
      S_WAIT_RELEASE: if (!spi.spi_done) state_d = S_NEXT;
      S_NEXT:         state_d = last ? S_IDLE : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    spi.spi_start = (state_q == S_ISSUE) && !spi.spi_done;
    seq_busy      = (state_q != S_IDLE);
    dbg_state_o   = state_q;
  end

  // Command table: not reset; writes are only allowed while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && !seq_busy) mem[cfg_addr] <= cfg_wdata;
  end

  // Datapath and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q     <= '0;
      len_q       <= '0;
      tmo_cnt_q   <= '0;
      spi_cmd_q   <= '0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_data_q  <= '0;
      seq_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      seq_done_q  <= 1'b0;
      if (accept) begin
        len_q   <= len_clamp;
        index_q <= '0;
        if (len_clamp == '0) seq_done_q <= 1'b1;
      end
      if (trigger && (seq_busy || seq_done_q)) overrun_q <= 1'b1;
      if (cfg_we && seq_busy) cfg_err_q <= 1'b1;
      case (state_q)
        S_FETCH: spi_cmd_q <= mem[index_q];
        S_ISSUE: tmo_cnt_q <= '0;
        S_WAIT_DONE: begin
          if (spi.spi_done) begin
            res_valid_q <= 1'b1;
            res_index_q <= index_q;
            res_data_q  <= spi.spi_rdata;
          end else if (tmo_hit) begin
            timeout_q  <= 1'b1;
            seq_done_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        S_NEXT: begin
          index_q <= index_q + AW'(1);
          if (last) seq_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign spi.spi_cmd = spi_cmd_q;
  assign res_valid   = res_valid_q;
  assign res_index   = res_index_q;
  assign res_data    = res_data_q;
  assign seq_done    = seq_done_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_rhs_cmd_sequencer.sv
module tb_rhs_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  localparam int AW = 2;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst, enable, trigger, cfg_we;
  logic [LW-1:0] seq_len;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_wdata;
  logic          res_valid, seq_busy, seq_done, overrun, timeout, cfg_err;
  logic [AW-1:0] res_index;
  logic [31:0]   res_data;
  logic [2:0]    dbg_state;

  rhs_cmd_sequencer_if spi ();

  rhs_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .seq_len(seq_len),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .spi(spi.master),
    .res_valid(res_valid), .res_index(res_index), .res_data(res_data),
    .seq_busy(seq_busy), .seq_done(seq_done), .overrun(overrun), .timeout(timeout),
    .cfg_err(cfg_err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // SPI master model: responds to each start after mdl_lat cycles with
  // rdata = ~cmd, holding done high for mdl_hold cycles.
  bit          mdl_en = 1'b1;
  int          mdl_lat = 1;
  int          mdl_hold = 2;
  int          mdl_phase = 0;
  int          mdl_cnt = 0;
  logic [31:0] mdl_cmd;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mdl_phase = 0;
      spi.spi_done = 1'b0;
      spi.spi_rdata = 32'h0;
    end else begin
      case (mdl_phase)
        0: if (mdl_en && spi.spi_start) begin
             mdl_cmd = spi.spi_cmd; mdl_cnt = mdl_lat; mdl_phase = 1;
           end
        1: if (mdl_cnt == 0) begin
             spi.spi_done = 1'b1; spi.spi_rdata = ~mdl_cmd; mdl_cnt = mdl_hold; mdl_phase = 2;
           end else mdl_cnt--;
        default: begin
          mdl_cnt--;
          if (mdl_cnt == 0) begin spi.spi_done = 1'b0; mdl_phase = 0; end
        end
      endcase
    end
  end

  // Scoreboard: expected command queue and observed traffic.
  logic [31:0] exp_q[$];
  logic [31:0] obs_cmd_q[$];
  logic [31:0] obs_idx_q[$];
  logic [31:0] obs_dat_q[$];
  int done_cnt = 0;
  int bad_start = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (spi.spi_start) obs_cmd_q.push_back(spi.spi_cmd);
      if (spi.spi_start && spi.spi_done) bad_start++;
      if (res_valid) begin
        obs_idx_q.push_back(32'(res_index));
        obs_dat_q.push_back(res_data);
      end
      if (seq_done) done_cnt++;
    end
  end

  // driver tasks
  task automatic clear_obs();
    obs_cmd_q.delete(); obs_idx_q.delete(); obs_dat_q.delete(); exp_q.delete();
    done_cnt = 0; bad_start = 0;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_trigger(input logic [LW-1:0] len);
    seq_len = len; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!seq_busy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_idle: sequence still busy after 400 cycles", name); end
  endtask

  task automatic check_traffic(input string name);
    checks++;
    if (obs_cmd_q.size() != exp_q.size() || obs_idx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: starts %0d results %0d exp %0d", name, obs_cmd_q.size(), obs_idx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_cmd_q.size() && i < obs_idx_q.size(); i++) begin
      checks++;
      if (obs_cmd_q[i] !== exp_q[i] || obs_idx_q[i] !== 32'(i) || obs_dat_q[i] !== ~exp_q[i]) begin
        errors++;
        $display("FAIL %s_item%0d: cmd %h idx %0d data %h exp cmd %h idx %0d data %h",
                 name, i, obs_cmd_q[i], obs_idx_q[i], obs_dat_q[i], exp_q[i], i, ~exp_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s_seq_done: got %0d pulses exp 1", name, done_cnt); end
    checks++;
    if (bad_start !== 0) begin errors++; $display("FAIL %s_start_during_done: got %0d exp 0", name, bad_start); end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi.spi_start, spi.spi_cmd, res_valid, res_index, res_data, seq_busy, seq_done,
         overrun, timeout, cfg_err, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_values: start %b cmd %h rv %b ri %0d rd %h busy %b done %b ov %b to %b ce %b st %0d exp all 0",
               spi.spi_start, spi.spi_cmd, res_valid, res_index, res_data, seq_busy, seq_done,
               overrun, timeout, cfg_err, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_obs();
    mdl_lat = 1; mdl_hold = 2;
    cfg_write(2'd0, 32'h11111111);
    cfg_write(2'd1, 32'h22222222);
    cfg_write(2'd2, 32'h33333333);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    pulse_trigger(3'd3);
    // FETCH cycle: busy, no start yet
    checks++;
    if (spi.spi_start !== 1'b0 || seq_busy !== 1'b1) begin
      errors++; $display("FAIL basic_fetch: start %b busy %b exp 0 1", spi.spi_start, seq_busy);
    end
    @(negedge clk);
    checks++;
    if (spi.spi_start !== 1'b1 || spi.spi_cmd !== 32'h11111111) begin
      errors++; $display("FAIL basic_first_start: start %b cmd %h exp 1 11111111", spi.spi_start, spi.spi_cmd);
    end
    wait_idle("basic");
    check_traffic("basic");
    checks++;
    if ({overrun, timeout, cfg_err} !== 3'b000) begin
      errors++; $display("FAIL basic_flags: got %b exp 000", {overrun, timeout, cfg_err});
    end
  endtask

  task automatic test_zero_len();
    clear_obs();
    pulse_trigger(3'd0);
    checks++;
    if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
      errors++; $display("FAIL zero_len_done: done %b busy %b exp 1 0", seq_done, seq_busy);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (seq_busy !== 1'b0 || seq_done !== 1'b0) begin
        errors++; $display("FAIL zero_len_after: busy %b done %b exp 0 0", seq_busy, seq_done);
      end
    end
    checks++;
    if (obs_cmd_q.size() != 0 || done_cnt != 1) begin
      errors++; $display("FAIL zero_len_traffic: starts %0d dones %0d exp 0 1", obs_cmd_q.size(), done_cnt);
    end
  endtask

  task automatic test_enable();
    clear_obs();
    enable = 1'b0;
    pulse_trigger(3'd2);
    repeat (4) @(negedge clk);
    checks++;
    if (seq_busy !== 1'b0 || obs_cmd_q.size() != 0 || done_cnt != 0) begin
      errors++; $display("FAIL enable_low: busy %b starts %0d dones %0d exp 0 0 0", seq_busy, obs_cmd_q.size(), done_cnt);
    end
    enable = 1'b1;
  endtask

  task automatic test_clamp();
    clear_obs();
    cfg_write(2'd3, 32'h44444444);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    pulse_trigger(3'd7);
    wait_idle("clamp");
    check_traffic("clamp");
  endtask

  task automatic test_cfg_same_cycle();
    clear_obs();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'hA5A5A5A5;
    seq_len = 3'd1; trigger = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; trigger = 1'b0;
    exp_q = '{32'hA5A5A5A5};
    wait_idle("cfg_same");
    check_traffic("cfg_same");
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_same_err: got %b exp 0", cfg_err); end
    cfg_write(2'd0, 32'h11111111);
  endtask

  task automatic test_long_done();
    clear_obs();
    mdl_lat = 0; mdl_hold = 17;
    exp_q = '{32'h11111111, 32'h22222222};
    pulse_trigger(3'd2);
    wait_idle("long_done");
    check_traffic("long_done");
    mdl_lat = 1; mdl_hold = 2;
  endtask

  task automatic test_timeout();
    int k;
    bit seen = 1'b0;
    clear_obs();
    mdl_en = 1'b0;
    pulse_trigger(3'd2);
    for (int i = 0; i < 10; i++) begin
      if (spi.spi_start) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    // One ISSUE cycle plus TIMEOUT cycles in WAIT_DONE before the flag shows.
    k = 0;
    while (seen && timeout !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (!seen || k != TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_latency: start seen %b cycles %0d exp %0d", seen, k, TIMEOUT + 1);
    end
    checks++;
    if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: done %b busy %b exp 1 0", seq_done, seq_busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_idx_q.size() != 0 || obs_cmd_q.size() != 1 || done_cnt != 1 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_traffic: results %0d starts %0d dones %0d flag %b exp 0 1 1 1",
               obs_idx_q.size(), obs_cmd_q.size(), done_cnt, timeout);
    end
    mdl_en = 1'b1;
  endtask

  task automatic test_overrun();
    clear_obs();
    checks++;
    if ({overrun, cfg_err} !== 2'b00) begin
      errors++; $display("FAIL overrun_pre: got %b exp 00", {overrun, cfg_err});
    end
    mdl_lat = 2; mdl_hold = 2;
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    pulse_trigger(3'd3);
    repeat (2) @(negedge clk);
    trigger = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    trigger = 1'b0; cfg_we = 1'b0;
    checks++;
    if (overrun !== 1'b1 || cfg_err !== 1'b1) begin
      errors++; $display("FAIL overrun_flags: ov %b ce %b exp 1 1", overrun, cfg_err);
    end
    wait_idle("overrun");
    check_traffic("overrun");
    // Table must still hold the original entry 0.
    clear_obs();
    exp_q = '{32'h11111111};
    pulse_trigger(3'd1);
    wait_idle("overrun_table");
    check_traffic("overrun_table");
    checks++;
    if (overrun !== 1'b1 || cfg_err !== 1'b1 || timeout !== 1'b1) begin
      errors++; $display("FAIL sticky_flags: ov %b ce %b to %b exp 1 1 1", overrun, cfg_err, timeout);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    clear_obs();
    mdl_lat = 6; mdl_hold = 1;
    pulse_trigger(3'd3);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (obs_idx_q.size() == 1 && spi.spi_start) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid_reach: entry 1 start not seen"); end
    @(negedge clk);
    checks++;
    if (dbg_state !== 3'd3) begin errors++; $display("FAIL reset_mid_state: got %0d exp 3", dbg_state); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({spi.spi_start, spi.spi_cmd, res_valid, res_index, res_data, seq_busy, seq_done,
         overrun, timeout, cfg_err, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid_values: start %b cmd %h rv %b ri %0d rd %h busy %b done %b ov %b to %b ce %b exp all 0",
               spi.spi_start, spi.spi_cmd, res_valid, res_index, res_data, seq_busy, seq_done,
               overrun, timeout, cfg_err);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_cmd_q.size() != 2 || seq_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_quiet: starts %0d busy %b exp 2 0", obs_cmd_q.size(), seq_busy);
    end
    clear_obs();
    mdl_lat = 1; mdl_hold = 2;
    exp_q = '{32'h11111111, 32'h22222222};
    pulse_trigger(3'd2);
    wait_idle("restart");
    check_traffic("restart");
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; trigger = 1'b0; cfg_we = 1'b0;
    seq_len = '0; cfg_addr = '0; cfg_wdata = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_enable();
    test_clamp();
    test_cfg_same_cycle();
    test_long_done();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
